psm_gen: RTL
============

# psm_gen

Parametrised successor to the three-phase processing state machine. On Start it captures two operands, then steps through three timed phases (Op1, Op2, Op3), each driving a one-hot phase flag and a phase-specific logic function of the captured operands. It returns to Idle, or loops back to Op1 when Loop is set. New over the fixed 8-bit version: configurable data and counter width, Hold (pause), Abort, a Done pulse, and loop mode. It sits between the control/sequencing logic and the datapath that consumes Dout and the phase flags.

## Interface
- DATA_W, 8, operand and result width
- CNT_W, 26, phase counter width; must satisfy 2^CNT_W > max(OP1_CYC, OP2_CYC, OP3_CYC)
- OP1_CYC, 50_000_000, Op1 duration in clocks (1000 ms at 50 MHz); must be ≥1
- OP2_CYC, 35_000_000, Op2 duration in clocks (700 ms); must be ≥1
- OP3_CYC, 25_000_000, Op3 duration in clocks (500 ms); must be ≥1

Ports:
- Clock  in  1  system clock, rising edge
- ResetN  in  1  asynchronous, active-low reset
- Din1  in  DATA_W  operand A, sampled on accepted Start
- Din2  in  DATA_W  operand B, sampled on accepted Start
- Start  in  1  level, sampled each clock; accepted only in Idle
- Hold  in  1  freezes the phase counter and state while high
- Abort  in  1  forces return to Idle; highest priority after reset
- Loop  in  1  sampled at Op3 expiry; if high, restart Op1 with fresh samples
- Ready  out  1  high only in Idle
- Op1, Op2, Op3  out  1 each  one-hot phase flags
- Dout  out  DATA_W  phase result; 0 in Idle
- Done  out  1  registered one-cycle pulse on normal completion (Op3 → Idle)

## Operation
- States: IDLE, OP1, OP2, OP3. Any illegal encoding recovers to IDLE.
- Reset values: state IDLE, counter 0, sample registers 0, Done 0. Resulting outputs: Ready 1, Op1–Op3 0, Dout 0.
- IDLE: if Start && !Abort at an edge, go to OP1, clear the counter, and capture A←Din1, B←Din2.
- OPn: while Hold=0, the counter increments each clock. When the counter reaches OPn_CYC−1, the next edge advances the state (OP1→OP2, OP2→OP3) and clears the counter.
- OP3 expiry:
  - Loop=1: go to OP1, recapture Din1/Din2, no Done.
  - Loop=0: go to IDLE and pulse Done for exactly one cycle.
- Hold=1: state and counter frozen. Outputs stay at the current phase values. Hold has no effect in IDLE (Start is still accepted).
- Abort=1 in any OP state: next edge goes to IDLE, counter cleared, no Done. Abort beats Hold, expiry and Start.
- Start while not in IDLE is ignored and has no queueing.
- Outputs (Moore, combinational decode of state and sample registers only):
  - OP1: Dout = A | B
  - OP2: Dout = A ^ B
  - OP3: Dout = ~(~A & B)
  - Ready = (state == IDLE)
- All arithmetic is unsigned. The counter never wraps, because it is cleared at expiry.

## Timing
- Start accepted at edge k: Op1 is high and Ready low from edge k through edge k+OP1_CYC. Op1 lasts exactly OP1_CYC cycles, and Op2/Op3 likewise, each extended by the number of Hold-high cycles.
- Total busy time without Hold: OP1_CYC+OP2_CYC+OP3_CYC cycles. Ready returns in the same cycle Done is high.
- Back-to-back: Start held high continuously restarts in the cycle after Ready returns, so there is one Idle cycle minimum.
- Abort latency: 1 clock.
- Reset asserted mid-phase: outputs go to reset values immediately (asynchronous). Operation resumes on the first edge after deassertion.

## Structure
- Package psm_gen_pkg: state enum (IDLE, OP1, OP2, OP3) and phase-function helper functions.
- Sub-module psm_phase_timer:
  - Inputs: clear, hold, limit (CNT_W).
  - Output: expire, combinational when count == limit−1 && !hold.
  - The top module muxes limit from OPn_CYC by state.

## Test plan
Use OP1_CYC=4, OP2_CYC=3, OP3_CYC=2, DATA_W=8 unless stated.
- Normal run: Din1=0x5A, Din2=0x0F, pulse Start → Op1 for 4 cycles with Dout=0x5F, Op2 for 3 cycles with 0x55, Op3 for 2 cycles with 0xFA, then Done for 1 cycle, Ready=1, Dout=0.
- Hold: assert Hold for 5 cycles during Op2 → Op2 lasts 8 cycles, total busy 14 cycles, Dout stays 0x55 throughout.
- Abort in 2nd Op1 cycle → Ready=1 next cycle, no Done. Abort together with Start in Idle → stays Idle.
- Loop=1 with Din changed to 0xFF/0x00 during Op2 → after Op3, Op1 again with Dout=0xFF. Drop Loop → Done after next Op3.
- Reset mid-Op3 → Ready=1, Op1–Op3=0, Dout=0, Done=0 immediately. Start ignored while ResetN=0.
- DATA_W=16, OP1_CYC=1 → Op1 lasts exactly 1 cycle. Start asserted during busy has no effect.

Source files
------------

// File: rtl/psm_gen_pkg.sv
// Shared types and phase functions for the parametrised three-phase processing state machine.
// Phase functions are bitwise, so they are defined per bit and applied across any data width.
package psm_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP1  = 2'd1,
    OP2  = 2'd2,
    OP3  = 2'd3
  } state_t;

  function automatic logic phase_op1_bit(input logic a, input logic b);
    return a | b;
  endfunction

  function automatic logic phase_op2_bit(input logic a, input logic b);
    return a ^ b;
  endfunction

  function automatic logic phase_op3_bit(input logic a, input logic b);
    return ~(~a & b);
  endfunction

  // Result bit for the given state; Idle always yields 0.
  function automatic logic phase_bit(input state_t st, input logic a, input logic b);
    logic r;
    case (st)
      OP1:     r = phase_op1_bit(a, b);
      OP2:     r = phase_op2_bit(a, b);
      OP3:     r = phase_op3_bit(a, b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/psm_gen_phase_timer.sv
// Phase duration counter: counts while not held, expires on the last cycle of a phase
// and restarts from zero on the following edge.
module psm_phase_timer #(
  parameter int CNT_W = 26
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             clear,
  input  logic             hold,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  assign expire = (count == (limit - CNT_W'(1))) && !hold;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (!hold) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/psm_gen.sv
// Three-phase processing state machine with configurable widths and phase lengths,
// plus Hold, Abort, Loop and a one-cycle Done pulse on normal completion.
module psm_gen
  import psm_gen_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 26,
  parameter int OP1_CYC = 50_000_000,
  parameter int OP2_CYC = 35_000_000,
  parameter int OP3_CYC = 25_000_000
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic [DATA_W-1:0] Din1,
  input  logic [DATA_W-1:0] Din2,
  input  logic              Start,
  input  logic              Hold,
  input  logic              Abort,
  input  logic              Loop,
  output logic              Ready,
  output logic              Op1,
  output logic              Op2,
  output logic              Op3,
  output logic [DATA_W-1:0] Dout,
  output logic              Done,
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0] LIM1 = CNT_W'(OP1_CYC);
  localparam logic [CNT_W-1:0] LIM2 = CNT_W'(OP2_CYC);
  localparam logic [CNT_W-1:0] LIM3 = CNT_W'(OP3_CYC);

  state_t             state;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic               done_q;
  logic [CNT_W-1:0]   limit;
  logic               timer_clear;
  logic               expire;

  // Counter sits at zero throughout Idle, so an accepted Start begins Op1 at count 0.
  assign timer_clear = (state == IDLE) || Abort;

  always_comb begin
    limit = LIM1;
    case (state)
      OP2:     limit = LIM2;
      OP3:     limit = LIM3;
      default: limit = LIM1;
    endcase
  end

  psm_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .Clock  (Clock),
    .ResetN (ResetN),
    .clear  (timer_clear),
    .hold   (Hold),
    .limit  (limit),
    .expire (expire)
  );

  // Hold is folded into expire, so a held phase simply never advances.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && !Abort) begin
            state <= OP1;
            a_q   <= Din1;
            b_q   <= Din2;
          end
        end
        OP1: begin
          if (Abort)       state <= IDLE;
          else if (expire) state <= OP2;
        end
        OP2: begin
          if (Abort)       state <= IDLE;
          else if (expire) state <= OP3;
        end
        OP3: begin
          if (Abort) begin
            state <= IDLE;
          end else if (expire) begin
            if (Loop) begin
              state <= OP1;
              a_q   <= Din1;
              b_q   <= Din2;
            end else begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    Dout = '0;
    for (int i = 0; i < DATA_W; i++) begin
      Dout[i] = phase_bit(state, a_q[i], b_q[i]);
    end
  end

  assign Ready     = (state == IDLE);
  assign Op1       = (state == OP1);
  assign Op2       = (state == OP2);
  assign Op3       = (state == OP3);
  assign Done      = done_q;
  assign dbg_state = state;

endmodule
